// File: rtl/priority_arb_enc.sv
// rtl/priority_arb_enc.sv - registered N-way priority arbiter with fixed/round-robin modes and valid/ack grant handshake
//
// Purpose:
//   Picks one of N level-sensitive requests, presents it as a one-hot grant
//   plus an index+1 code, holds it until the consumer acknowledges, and counts
//   accepted grants. Supports fixed priority (highest index wins) and
//   round-robin priority (last winner becomes lowest priority).
//
// Ports:
//   clk        in  1      sole clock, rising edge
//   rst        in  1      synchronous active-high reset
//   w          in  N      request lines, bit i = request i
//   rr_mode    in  1      0 = fixed priority, 1 = round-robin
//   ack        in  1      consumer accepts current grant (ignored when idle)
//   valid      out 1      a grant is presented
//   z          out ZW     winner index + 1, 0 when no grant
//   grant      out N      one-hot winner, zero when valid = 0
//   grant_cnt  out CNT_W  accepted grant count, wraps silently

module priority_arb_enc #(
  parameter int N     = 4,
  parameter int ZW    = $clog2(N + 1),
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     w,
  input  logic             rr_mode,
  input  logic             ack,
  output logic             valid,
  output logic [ZW-1:0]    z,
  output logic [N-1:0]     grant,
  output logic [CNT_W-1:0] grant_cnt
);

  localparam int PW = $clog2(N);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  logic [0:0]       r_state;
  logic [PW-1:0]    r_idx;
  logic [PW-1:0]    r_ptr;
  logic [ZW-1:0]    r_z;
  logic [N-1:0]     r_grant;
  logic [CNT_W-1:0] r_cnt;

  logic             w_any;
  logic             w_accept;
  logic [PW-1:0]    w_arb_ptr;
  logic [PW-1:0]    w_fix_idx;
  logic             w_lo_found;
  logic [PW-1:0]    w_lo_idx;
  logic [PW-1:0]    w_hi_idx;
  logic [PW-1:0]    w_rr_idx;
  logic [PW-1:0]    w_win_idx;
  logic [ZW-1:0]    w_win_z;
  logic [N-1:0]     w_win_grant;

  assign w_any    = |w;
  assign w_accept = (r_state == S_GRANT) && ack;

  // On an accepted grant the pointer moves to the current winner in the same
  // edge, so the back-to-back re-arbitration must already see that new value.
  assign w_arb_ptr = w_accept ? r_idx : r_ptr;

  // Fixed priority: ascending scan, the last set bit seen (highest index) wins.
  always_comb begin
    w_fix_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (w[i]) begin
        w_fix_idx = PW'(i);
      end
    end
  end

  // Round-robin search order is ptr-1 down to 0, then N-1 down to ptr.
  // That is the highest set index below ptr if one exists, otherwise the
  // highest set index at or above ptr. With ptr = 0 this reduces to fixed.
  always_comb begin
    w_lo_found = 1'b0;
    w_lo_idx   = '0;
    w_hi_idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (w[i]) begin
        if (PW'(i) < w_arb_ptr) begin
          w_lo_found = 1'b1;
          w_lo_idx   = PW'(i);
        end else begin
          w_hi_idx = PW'(i);
        end
      end
    end
  end

  assign w_rr_idx    = w_lo_found ? w_lo_idx : w_hi_idx;
  assign w_win_idx   = rr_mode ? w_rr_idx : w_fix_idx;
  assign w_win_z     = ZW'(w_win_idx) + ZW'(1);
  assign w_win_grant = N'(1) << w_win_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_ptr   <= '0;
      r_z     <= '0;
      r_grant <= '0;
      r_cnt   <= '0;
    end else if (r_state == S_IDLE) begin
      // ack is ignored here: nothing is presented, so nothing is accepted.
      if (w_any) begin
        r_state <= S_GRANT;
        r_idx   <= w_win_idx;
        r_z     <= w_win_z;
        r_grant <= w_win_grant;
      end
    end else if (ack) begin
      r_cnt <= r_cnt + CNT_W'(1);
      r_ptr <= r_idx;
      if (w_any) begin
        r_idx   <= w_win_idx;
        r_z     <= w_win_z;
        r_grant <= w_win_grant;
      end else begin
        r_state <= S_IDLE;
        r_z     <= '0;
        r_grant <= '0;
      end
    end
    // GRANT without ack: hold everything, requests are not re-sampled.
  end

  assign valid     = (r_state == S_GRANT);
  assign z         = r_z;
  assign grant     = r_grant;
  assign grant_cnt = r_cnt;

endmodule

// File: tb/tb_priority_arb_enc.sv
// tb/tb_priority_arb_enc.sv - randomized and directed self-checking bench for priority_arb_enc
module tb_priority_arb_enc;

  localparam int NB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] w;
  logic          rr_mode;
  logic          ack;

  logic          valid;
  logic [2:0]    z;
  logic [NB-1:0] grant;
  logic [7:0]    grant_cnt;

  logic          n_valid;
  logic [2:0]    n_z;
  logic [NB-1:0] n_grant;
  logic [2:0]    n_grant_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  bit m_valid;
  int m_idx;
  int m_ptr;
  int m_cnt;

  always #5 clk = ~clk;

  priority_arb_enc #(.N(NB)) dut (
    .clk(clk), .rst(rst), .w(w), .rr_mode(rr_mode), .ack(ack),
    .valid(valid), .z(z), .grant(grant), .grant_cnt(grant_cnt)
  );

  priority_arb_enc #(.N(NB), .CNT_W(3)) dut_n (
    .clk(clk), .rst(rst), .w(w), .rr_mode(rr_mode), .ack(ack),
    .valid(n_valid), .z(n_z), .grant(n_grant), .grant_cnt(n_grant_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int arb(input logic [NB-1:0] req, input logic rr, input int ptr);
    if (!rr) begin
      for (int i = NB - 1; i >= 0; i--) begin
        if (req[i]) return i;
      end
    end else begin
      for (int k = 1; k <= NB; k++) begin
        int j;
        j = (ptr - k + NB) % NB;
        if (req[j]) return j;
      end
    end
    return -1;
  endfunction

  task automatic model_step(input logic r, input logic [NB-1:0] wv, input logic rrv, input logic av);
    if (r) begin
      m_valid = 0; m_idx = 0; m_ptr = 0; m_cnt = 0;
    end else if (!m_valid) begin
      if (wv != 0) begin
        m_idx   = arb(wv, rrv, m_ptr);
        m_valid = 1;
      end
    end else if (av) begin
      m_cnt = m_cnt + 1;
      m_ptr = m_idx;
      if (wv != 0) m_idx = arb(wv, rrv, m_ptr);
      else m_valid = 0;
    end
  endtask

  task automatic cyc(input logic r, input logic [NB-1:0] wv, input logic rrv, input logic av);
    logic [31:0] ez;
    logic [31:0] eg;
    rst = r; w = wv; rr_mode = rrv; ack = av;
    @(posedge clk);
    model_step(r, wv, rrv, av);
    #1;
    ez = m_valid ? 32'(m_idx + 1) : 32'd0;
    eg = m_valid ? (32'd1 << m_idx) : 32'd0;
    chk("valid", 32'(valid), 32'(m_valid));
    chk("z", 32'(z), ez);
    chk("grant", 32'(grant), eg);
    chk("grant_cnt", 32'(grant_cnt), 32'(m_cnt % 256));
    chk("n_valid", 32'(n_valid), 32'(m_valid));
    chk("n_z", 32'(n_z), ez);
    chk("n_grant_cnt", 32'(n_grant_cnt), 32'(m_cnt % 8));
  endtask

  initial begin
    int exp_z [6];
    rst = 1'b1; w = '0; rr_mode = 1'b0; ack = 1'b0;
    m_valid = 0; m_idx = 0; m_ptr = 0; m_cnt = 0;

    // reset and idle
    cyc(1, 4'b1111, 0, 0);
    cyc(1, 4'b1111, 0, 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_cnt", 32'(grant_cnt), 0);
    for (int i = 0; i < 5; i++) cyc(0, 4'b0000, 0, 0);
    chk("idle_z", 32'(z), 0);

    // fixed priority and hold
    cyc(0, 4'b0110, 0, 0);
    chk("fix_z", 32'(z), 3);
    chk("fix_grant", 32'(grant), 4'b0100);
    for (int i = 0; i < 10; i++) cyc(0, 4'b0001, 0, 0);
    chk("hold_z", 32'(z), 3);
    cyc(0, 4'b0001, 0, 1);
    chk("ack_z", 32'(z), 1);
    chk("ack_cnt", 32'(grant_cnt), 1);
    cyc(0, 4'b0000, 0, 1);
    chk("last_ack_valid", 32'(valid), 0);

    // round-robin fairness
    cyc(1, 4'b0000, 0, 0);
    exp_z = '{4, 3, 2, 1, 4, 3};
    for (int i = 0; i < 6; i++) begin
      cyc(0, 4'b1111, 1, 1);
      chk("rr_z", 32'(z), 32'(exp_z[i]));
      chk("rr_cnt", 32'(grant_cnt), 32'(i));
      chk("rr_valid", 32'(valid), 1);
    end

    // round-robin sparse
    cyc(1, 4'b0000, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 4'b1010, 1, 1);
      chk("sparse_z", 32'(z), (i % 2 == 0) ? 32'd4 : 32'd2);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 4'b1000, 1, 1);
      chk("single_z", 32'(z), 4);
    end

    // reset mid-grant with ack, then ack in idle
    cyc(1, 4'b0000, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 4'b1111, 0, 1);
    chk("pre_rst_cnt", 32'(grant_cnt), 5);
    cyc(1, 4'b1111, 0, 1);
    chk("mid_rst_valid", 32'(valid), 0);
    chk("mid_rst_grant", 32'(grant), 0);
    chk("mid_rst_cnt", 32'(grant_cnt), 0);
    cyc(0, 4'b0000, 0, 1);
    cyc(0, 4'b0000, 0, 1);
    chk("idle_ack_cnt", 32'(grant_cnt), 0);

    // counter wrap on the 3-bit instance
    cyc(1, 4'b0000, 0, 0);
    cyc(0, 4'b0011, 0, 1);
    for (int i = 1; i <= 9; i++) begin
      cyc(0, 4'b0011, 0, 1);
      chk("wrap_cnt", 32'(n_grant_cnt), 32'(i % 8));
      chk("wrap_valid", 32'(n_valid), 1);
    end

    // randomized
    cyc(1, 4'b0000, 0, 0);
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 39) == 0), NB'($urandom), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 3) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/priority_arb_enc.md
# priority_arb_enc

Registered, parametrised successor to the team's 4-input combinational priority encoder. Accepts `N` level-sensitive request lines, selects one winner with either fixed (highest-index-wins) or round-robin priority, and presents the winner as an index+1 code plus a one-hot grant. The grant is held under a valid/ack handshake and counted. It sits between request sources and a single shared consumer, such as a display or bus mux, on one clock.

## Interface
Parameters:
- `N`, default 4: number of request lines, 2..16.
- `ZW`, default `$clog2(N+1)`: code width. Must be wide enough to hold N; do not override.
- `CNT_W`, default 8: grant counter width.

Ports:
- `clk` in 1: sole clock. All state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `w` in N: request lines, level-sensitive. Bit i is request i.
- `rr_mode` in 1: priority mode. 0 = fixed priority, highest index wins. 1 = round-robin.
- `ack` in 1: consumer accepts the current grant. Only meaningful while `valid`=1.
- `valid` out 1: a grant is presented.
- `z` out ZW: winner index+1. 0 = no grant.
- `grant` out N: one-hot winner. All zeros when `valid`=0.
- `grant_cnt` out CNT_W: number of accepted grants (ack while valid). Wraps modulo 2^CNT_W.

## Operation
- FSM has two states.
  - IDLE: `valid`=0, `z`=0, `grant`=0.
  - GRANT: `valid`=1; `z` and `grant` are registered and stable.
- IDLE:
  - If `w`≠0, compute the winner, register `z`/`grant`, and go to GRANT.
  - Otherwise stay in IDLE.
- GRANT with `ack`=0: hold all outputs. Requests are not re-sampled; withdrawal of the granted request does not drop the grant.
- GRANT with `ack`=1:
  - `grant_cnt` += 1.
  - Round-robin pointer `ptr` ← winner index.
  - Re-arbitrate on the current `w`, using the updated `ptr`.
  - If `w`≠0, stay in GRANT with the new winner (back-to-back). Otherwise go to IDLE and clear the outputs.
- Fixed-priority winner: the highest i with `w[i]`=1. For N=4 this matches the legacy encoder: w[3]→`z`=4, w[2]→3, w[1]→2, w[0]→1.
- Round-robin winner: the first set bit searching downward from `ptr-1`, wrapping through N-1, and ending at `ptr`. The last winner therefore has lowest priority.
- `ptr` updates on every ack in both modes. Fixed mode ignores `ptr`.
- With `ptr`=0, round-robin order equals fixed order.
- `rr_mode` is sampled only at arbitration instants. A change while holding has no effect on the held grant.
- `ack` in IDLE is ignored: no count, no pointer change.
- Invariant: `z` = index(`grant`)+1 whenever `valid`=1.

## Timing
- Reset state after the edge with `rst`=1: IDLE, `valid`=0, `z`=0, `grant`=0, `grant_cnt`=0, `ptr`=0.
- `rst` overrides everything, including an `ack` in the same cycle.
- Reset mid-grant clears the grant with no count increment.
- Latency: a request seen at edge k (in IDLE) gives `valid`=1 after edge k.
- Back-to-back: an ack at edge k with pending requests presents the new winner after edge k, with no idle bubble.
- The last ack with `w`=0 gives `valid`=0 after that edge.
- `grant_cnt` wrap: 2^CNT_W−1 + 1 → 0, with no flag.
- No combinational path from `w`, `ack` or `rr_mode` to any output; all outputs are registered.

## Test plan
1. Reset and idle:
   - Stimulus: assert `rst` for 2 cycles with `w`=4'b1111, then release with `w`=0 for 5 cycles.
   - Response: `valid`=0, `z`=0, `grant`=0, `grant_cnt`=0 throughout.
2. Fixed priority and hold (N=4, `rr_mode`=0):
   - Stimulus: `w`=4'b0110, `ack`=0.
   - Response: one cycle later `z`=3'b011 and `grant`=4'b0100. The grant holds for 10 cycles even after `w` changes to 4'b0001.
   - Then `ack`=1 for one cycle with `w`=4'b0001: next cycle `z`=3'b001, `grant_cnt`=1.
3. Round-robin fairness:
   - Stimulus: `rr_mode`=1, `w`=4'b1111, `ack`=1 continuously.
   - Response: `z` sequence 4,3,2,1,4,3 on consecutive cycles, `valid` never drops, `grant_cnt` increments by 1 per cycle.
4. Round-robin with sparse requests:
   - Stimulus: from reset, `w`=4'b1010 with `ack` every cycle.
   - Response: `z` alternates 4,2,4,2. Then set `w`=4'b1000: `z` stays 4 on every grant.
5. Reset mid-operation and ack in IDLE:
   - Stimulus: assert `rst` with `ack`=1 while in GRANT with `grant_cnt`=5.
   - Response: next cycle all outputs are 0 and `grant_cnt`=0.
   - Stimulus: pulse `ack` in IDLE.
   - Response: `grant_cnt` stays 0.
6. Counter wrap:
   - Stimulus: `CNT_W`=3, 9 accepted grants.
   - Response: `grant_cnt` goes 1..7, 0, 1. Grants remain uninterrupted across the wrap.
